exc_sched: RTL and testbench

Exception/interrupt sequencer for the 5-stage MIPS pipeline, sitting beside the M stage. It consumes the exception code carried down from fetch/decode/execute, together with external interrupts. It picks at most one event per cycle, flushes the pipeline, and redirects fetch to the handler at 0x0000_4180 or back to EPC on `eret`. It owns the SR, Cause and EPC registers and exposes them through the CP0 read/write port.

---
 rtl/exc_sched.sv | 165 ++++++++++++++++
 tb/tb_exc_sched.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exc_sched.sv
// Exception/interrupt sequencer beside the M stage: owns SR/Cause/EPC, flushes and redirects fetch.
// Define EXC_SCHED_INT_EN to build the external interrupt path (hw_int, SR.IM/IE, Cause.IP).
module exc_sched #(
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [31:0] TEXT_LO    = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        m_valid,
    input  logic        exc_m_req,
    input  logic [6:2]  exc_m_code,
    input  logic [31:0] pc_m,
    input  logic        bd_m,
    input  logic        eret_m,
    input  logic [7:2]  hw_int,
    input  logic        cp0_we,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] cp0_wdata,
    output logic [31:0] cp0_rdata,
    output logic        flush,
    output logic        redirect_valid,
    input  logic        redirect_ready,
    output logic [31:0] redirect_pc,
    output logic        exl
);

    localparam int unsigned XLEN   = 32;
    localparam int unsigned IRQ_W  = 6;
    localparam int unsigned CODE_W = 5;

    localparam logic [4:0] ADDR_SR    = 5'd12;
    localparam logic [4:0] ADDR_CAUSE = 5'd13;
    localparam logic [4:0] ADDR_EPC   = 5'd14;

    typedef enum logic [1:0] {
        RUN,
        FLUSH,
        REDIR
    } stateE;

    stateE              state;
    logic [IRQ_W-1:0]   srIm;
    logic               srIe;
    logic [IRQ_W-1:0]   causeIp;
    logic               causeBd;
    logic [CODE_W-1:0]  causeCode;
    logic [XLEN-1:0]    epc;
    logic [XLEN-1:0]    target;

    logic               intPend;
    logic               takeExc;
    logic               takeEret;
    logic               cp0Wr;
    logic [CODE_W-1:0]  excCode;
    logic [XLEN-1:0]    epcRaw;
    logic [XLEN-1:0]    epcEntry;
    logic [XLEN-1:0]    epcAligned;
    logic [XLEN-1:0]    epcWrite;

    // Event selection and EPC candidates; interrupts outrank synchronous exceptions.
    always_comb begin
        takeExc    = intPend | (m_valid & exc_m_req);
        excCode    = intPend ? CODE_W'(0) : exc_m_code;
        takeEret   = m_valid & eret_m & exl;
        cp0Wr      = (state == RUN) & ~takeExc & ~takeEret & cp0_we;
        epcRaw     = bd_m ? (pc_m - XLEN'(4)) : pc_m;
        epcEntry   = (epcRaw < TEXT_LO) ? TEXT_LO : epcRaw;
        epcAligned = {cp0_wdata[31:2], 2'b00};
        epcWrite   = (epcAligned < TEXT_LO) ? TEXT_LO : epcAligned;
    end

`ifdef EXC_SCHED_INT_EN
    assign intPend = (|(causeIp & srIm)) & srIe & ~exl;

    // Interrupt lines are re-sampled every cycle, so a held line stays pending.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            causeIp <= '0;
            srIm    <= '0;
            srIe    <= 1'b0;
        end else begin
            causeIp <= hw_int;
            if (cp0Wr && (cp0_addr == ADDR_SR)) begin
                srIm <= cp0_wdata[15:10];
                srIe <= cp0_wdata[0];
            end
        end
    end
`else
    logic unusedIntInputs;

    assign intPend         = 1'b0;
    assign causeIp         = '0;
    assign srIm            = '0;
    assign srIe            = 1'b0;
    assign unusedIntInputs = ^{hw_int, cp0_wdata[0]};
`endif

    // Sequencer: RUN -> FLUSH (one-cycle kill) -> REDIR (hold until fetch accepts).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= RUN;
            flush          <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            exl            <= 1'b0;
            causeBd        <= 1'b0;
            causeCode      <= '0;
            epc            <= '0;
            target         <= '0;
        end else begin
            flush <= 1'b0;
            case (state)
                RUN: begin
                    if (takeExc) begin
                        causeCode <= excCode;
                        causeBd   <= bd_m;
                        epc       <= epcEntry;
                        exl       <= 1'b1;
                        target    <= HANDLER_PC;
                        flush     <= 1'b1;
                        state     <= FLUSH;
                    end else if (takeEret) begin
                        exl    <= 1'b0;
                        target <= epc;
                        flush  <= 1'b1;
                        state  <= FLUSH;
                    end else if (cp0Wr) begin
                        if (cp0_addr == ADDR_SR) begin
                            exl <= cp0_wdata[1];
                        end else if (cp0_addr == ADDR_EPC) begin
                            epc <= epcWrite;
                        end
                    end
                end
                FLUSH: begin
                    redirect_valid <= 1'b1;
                    redirect_pc    <= target;
                    state          <= REDIR;
                end
                REDIR: begin
                    if (redirect_ready) begin
                        redirect_valid <= 1'b0;
                        state          <= RUN;
                    end
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

    // CP0 read port; unimplemented registers and fields read as zero.
    always_comb begin
        cp0_rdata = '0;
        case (cp0_addr)
            ADDR_SR:    cp0_rdata = {16'h0, srIm, 8'h0, exl, srIe};
            ADDR_CAUSE: cp0_rdata = {causeBd, 15'h0, causeIp, 3'h0, causeCode, 2'h0};
            ADDR_EPC:   cp0_rdata = epc;
            default:    cp0_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_exc_sched.sv
// Scoreboard bench for exc_sched: directed scenarios then randomized traffic against a register-level model.
module tb_exc_sched;

    localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
    localparam logic [31:0] TEXT_LO    = 32'h0000_3000;
`ifdef EXC_SCHED_INT_EN
    localparam bit INT_EN = 1'b1;
`else
    localparam bit INT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        m_valid;
    logic        exc_m_req;
    logic [6:2]  exc_m_code;
    logic [31:0] pc_m;
    logic        bd_m;
    logic        eret_m;
    logic [7:2]  hw_int;
    logic        cp0_we;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic [31:0] cp0_rdata;
    logic        flush;
    logic        redirect_valid;
    logic        redirect_ready;
    logic [31:0] redirect_pc;
    logic        exl;

    exc_sched #(.HANDLER_PC(HANDLER_PC), .TEXT_LO(TEXT_LO)) dut (
        .clk(clk), .reset_n(reset_n), .m_valid(m_valid), .exc_m_req(exc_m_req),
        .exc_m_code(exc_m_code), .pc_m(pc_m), .bd_m(bd_m), .eret_m(eret_m),
        .hw_int(hw_int), .cp0_we(cp0_we), .cp0_addr(cp0_addr), .cp0_wdata(cp0_wdata),
        .cp0_rdata(cp0_rdata), .flush(flush), .redirect_valid(redirect_valid),
        .redirect_ready(redirect_ready), .redirect_pc(redirect_pc), .exl(exl)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int edgeNo = 0;
    always @(posedge clk) edgeNo <= edgeNo + 1;

    typedef struct {
        int          at;
        logic [31:0] pc;
        logic        exl;
    } redirT;

    int    flushQ[$];
    redirT redirQ[$];

    // Architectural model: register contents plus whether an event is still in flight.
    logic [5:0]  mIm, mIp;
    logic        mIe, mExl, mBd;
    logic [4:0]  mCode;
    logic [31:0] mEpc;
    bit          busy;
    int          age;

    function automatic void modelReset();
        mIm = '0; mIp = '0; mIe = 1'b0; mExl = 1'b0; mBd = 1'b0;
        mCode = '0; mEpc = '0; busy = 1'b0; age = 0;
    endfunction

    function automatic logic [31:0] modelRead(input logic [4:0] a);
        case (a)
            5'd12:   return {16'h0, mIm, 8'h0, mExl, mIe};
            5'd13:   return {mBd, 15'h0, mIp, 3'h0, mCode, 2'h0};
            5'd14:   return mEpc;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] clampPc(input logic [31:0] p);
        return (p < TEXT_LO) ? TEXT_LO : p;
    endfunction

    function automatic void enter(input logic [31:0] tgt);
        redirT r;
        busy = 1'b1;
        age  = 0;
        flushQ.push_back(edgeNo + 1);
        r.at  = edgeNo + 2;
        r.pc  = tgt;
        r.exl = mExl;
        redirQ.push_back(r);
    endfunction

    // Effect of the coming clock edge given the inputs currently driven.
    function automatic void modelStep();
        bit pend;
        if (!busy) begin
            pend = INT_EN && ((mIp & mIm) != 6'h0) && mIe && !mExl;
            if (pend || (m_valid && exc_m_req)) begin
                mCode = pend ? 5'd0 : exc_m_code;
                mBd   = bd_m;
                mEpc  = clampPc(bd_m ? pc_m - 32'd4 : pc_m);
                mExl  = 1'b1;
                enter(HANDLER_PC);
            end else if (m_valid && eret_m && mExl) begin
                mExl = 1'b0;
                enter(mEpc);
            end else if (cp0_we) begin
                if (cp0_addr == 5'd12) begin
                    mExl = cp0_wdata[1];
                    mIm  = INT_EN ? cp0_wdata[15:10] : 6'h0;
                    mIe  = INT_EN ? cp0_wdata[0] : 1'b0;
                end else if (cp0_addr == 5'd14) begin
                    mEpc = clampPc({cp0_wdata[31:2], 2'b00});
                end
            end
        end else begin
            age++;
            if (age >= 2 && redirect_ready) busy = 1'b0;
        end
        mIp = INT_EN ? hw_int : 6'h0;
    endfunction

    task automatic expect32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string name);
        cp0_addr = a;
        #1;
        expect32(name, cp0_rdata, exp);
    endtask

    task automatic idle();
        m_valid = 1'b0; exc_m_req = 1'b0; exc_m_code = 5'd0; pc_m = 32'h3000;
        bd_m = 1'b0; eret_m = 1'b0; hw_int = 6'h0; cp0_we = 1'b0;
        cp0_addr = 5'd0; cp0_wdata = 32'h0; redirect_ready = 1'b1;
    endtask

    // Called at a falling edge with inputs already driven.
    task automatic tick();
        #1;
        expect32("cp0_read", cp0_rdata, modelRead(cp0_addr));
        expect1("exl_out", exl, mExl);
        modelStep();
        @(negedge clk);
    endtask

    // Monitor: pops expectations when flush / redirect activity is due.
    logic  prevV = 1'b0;
    logic [31:0] prevPc = 32'h0;
    int    fDue;
    redirT monR;
    always @(posedge clk) begin
        #1;
        if (!reset_n) begin
            prevV = 1'b0;
        end else begin
            if (flushQ.size() != 0 && flushQ[0] <= edgeNo) begin
                fDue = flushQ.pop_front();
                checks++;
                if (flush !== 1'b1) begin
                    errors++;
                    $display("FAIL flush_missing: edge %0d got %b expected 1", fDue, flush);
                end
            end else begin
                checks++;
                if (flush !== 1'b0) begin
                    errors++;
                    $display("FAIL flush_unexpected: edge %0d got %b expected 0", edgeNo, flush);
                end
            end
            if (prevV) begin
                checks++;
                if (redirect_valid !== ~redirect_ready ||
                    (redirect_valid && redirect_pc !== prevPc)) begin
                    errors++;
                    $display("FAIL redir_hold: valid %b pc %h expected valid %b pc %h",
                             redirect_valid, redirect_pc, ~redirect_ready, prevPc);
                end
            end else if (redirQ.size() != 0 && redirQ[0].at <= edgeNo) begin
                monR = redirQ.pop_front();
                checks++;
                if (redirect_valid !== 1'b1 || redirect_pc !== monR.pc || exl !== monR.exl) begin
                    errors++;
                    $display("FAIL redir_issue: valid %b pc %h exl %b expected valid 1 pc %h exl %b",
                             redirect_valid, redirect_pc, exl, monR.pc, monR.exl);
                end
            end else begin
                checks++;
                if (redirect_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL redir_unexpected: valid %b expected 0", redirect_valid);
                end
            end
            prevV  = redirect_valid;
            prevPc = redirect_pc;
        end
    end

    initial begin
        reset_n = 1'b0;
        idle();
        modelReset();
        #2;
        expect1("rst_flush", flush, 1'b0);
        expect1("rst_rv", redirect_valid, 1'b0);
        expect32("rst_rpc", redirect_pc, 32'h0);
        rd(5'd12, 32'h0, "rst_sr");
        rd(5'd13, 32'h0, "rst_cause");
        rd(5'd14, 32'h0, "rst_epc");
        @(negedge clk);
        reset_n = 1'b1;

        // AdEL, not in a delay slot
        m_valid = 1'b1; exc_m_req = 1'b1; exc_m_code = 5'd4; pc_m = 32'h3008;
        tick();
        idle();
        expect1("adel_flush", flush, 1'b1);
        tick();
        expect1("adel_rv", redirect_valid, 1'b1);
        expect32("adel_rpc", redirect_pc, 32'h0000_4180);
        tick();
        tick();
        rd(5'd14, 32'h3008, "adel_epc");
        rd(5'd13, 32'h10, "adel_cause");
        expect1("adel_exl", exl, 1'b1);
        tick();

        // Overflow in a delay slot
        m_valid = 1'b1; exc_m_req = 1'b1; exc_m_code = 5'd12; pc_m = 32'h3010; bd_m = 1'b1;
        tick();
        idle();
        tick(); tick(); tick();
        rd(5'd14, 32'h300C, "ov_epc");
        rd(5'd13, 32'h8000_0030, "ov_cause");
        tick();

        // ERET back to a written EPC, then ERET with EXL clear
        cp0_we = 1'b1; cp0_addr = 5'd14; cp0_wdata = 32'h3021;
        tick();
        idle();
        rd(5'd14, 32'h3020, "epc_write");
        m_valid = 1'b1; eret_m = 1'b1;
        tick();
        idle();
        expect1("eret_flush", flush, 1'b1);
        tick();
        expect1("eret_rv", redirect_valid, 1'b1);
        expect32("eret_rpc", redirect_pc, 32'h3020);
        expect1("eret_exl", exl, 1'b0);
        tick(); tick();
        m_valid = 1'b1; eret_m = 1'b1;
        tick();
        idle();
        expect1("eret_noexl_flush", flush, 1'b0);
        tick();
        expect1("eret_noexl_rv", redirect_valid, 1'b0);

        // Interrupt and exception in the same cycle
        cp0_we = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_0401;
        tick();
        idle();
        rd(5'd12, INT_EN ? 32'h0000_0401 : 32'h0, "sr_write");
        hw_int = 6'b000001;
        tick();
        hw_int = 6'b000001; m_valid = 1'b1; exc_m_req = 1'b1; exc_m_code = 5'd10; pc_m = 32'h3040;
        tick();
        idle();
        tick(); tick(); tick();
        rd(5'd14, 32'h3040, "int_epc");
        rd(5'd13, INT_EN ? 32'h0 : 32'h28, "int_cause");
        tick();

        // Handshake stall with a competing exception held high
        m_valid = 1'b1; exc_m_req = 1'b1; exc_m_code = 5'd5; pc_m = 32'h3050; redirect_ready = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            expect1("hs_hold_rv", redirect_valid, 1'b1);
            expect32("hs_hold_pc", redirect_pc, HANDLER_PC);
            tick();
        end
        redirect_ready = 1'b1;
        tick();
        expect1("hs_done_rv", redirect_valid, 1'b0);
        tick();
        expect1("hs_rerun_flush", flush, 1'b1);
        idle();
        tick(); tick(); tick();

        // Reset while a redirect is outstanding
        m_valid = 1'b1; exc_m_req = 1'b1; exc_m_code = 5'd4; pc_m = 32'h3060; redirect_ready = 1'b0;
        tick();
        idle();
        redirect_ready = 1'b0;
        tick();
        expect1("rst_mid_pre_rv", redirect_valid, 1'b1);
        #1;
        reset_n = 1'b0;
        modelReset();
        flushQ.delete();
        redirQ.delete();
        #1;
        expect1("rst_mid_flush", flush, 1'b0);
        expect1("rst_mid_rv", redirect_valid, 1'b0);
        expect32("rst_mid_rpc", redirect_pc, 32'h0);
        expect1("rst_mid_exl", exl, 1'b0);
        rd(5'd12, 32'h0, "rst_mid_sr");
        rd(5'd13, 32'h0, "rst_mid_cause");
        rd(5'd14, 32'h0, "rst_mid_epc");
        @(negedge clk);
        reset_n = 1'b1;
        idle();

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            m_valid        = ($urandom_range(0, 3) != 0);
            exc_m_req      = ($urandom_range(0, 7) == 0);
            exc_m_code     = 5'($urandom_range(0, 31));
            pc_m           = 32'($urandom_range(0, 32'h8000)) & 32'hFFFF_FFFC;
            bd_m           = ($urandom_range(0, 1) == 1);
            eret_m         = ($urandom_range(0, 5) == 0);
            hw_int         = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(1, 63)) : 6'h0;
            cp0_we         = ($urandom_range(0, 4) == 0);
            cp0_addr       = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                                         : 5'(12 + $urandom_range(0, 2));
            cp0_wdata      = $urandom;
            redirect_ready = ($urandom_range(0, 1) == 1);
            tick();
        end

        idle();
        for (int n = 0; n < 10; n++) tick();
        checks++;
        if (flushQ.size() != 0 || redirQ.size() != 0) begin
            errors++;
            $display("FAIL drain: pending flush %0d redirect %0d expected 0 0",
                     flushQ.size(), redirQ.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
